// File: rtl/wb_burst_responder.sv
// Wishbone responder with an internal word memory.
//
// Accepts classic cycles and registered-feedback bursts: incrementing (cti=010),
// linear or wrapping in 4/8/16-word blocks (bte), and terminated by cti=111 or a
// return to classic. It has programmable wait states before the first beat,
// byte-lane writes, err for out-of-range addresses and rty on request.
//
// Ports:
//   clk_i        bus clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cyc_i/stb_i  cycle valid / strobe
//   we_i         1 = write, 0 = read
//   adr_i        word address
//   dout_i       write data from the initiator
//   sel_i        byte-lane enables
//   cti_i/bte_i  cycle type / burst wrap mode
//   wait_cfg_i   wait states before the first beat, sampled at acceptance
//   rty_req_i    answer the accepted transfer with rty
//   din_o        read data, zero whenever ack_o is low
//   ack_o/err_o/rty_o  terminations, gated by cyc_i & stb_i
module wb_burst_responder #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 16,
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned MAX_WAIT      = 15
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 cyc_i,
  input  logic                                 stb_i,
  input  logic                                 we_i,
  input  logic [WB_ADDR_WIDTH-1:0]             adr_i,
  input  logic [WB_DATA_WIDTH-1:0]             dout_i,
  input  logic [WB_DATA_WIDTH/8-1:0]           sel_i,
  input  logic [2:0]                           cti_i,
  input  logic [1:0]                           bte_i,
  input  logic [$clog2(MAX_WAIT+1)-1:0]        wait_cfg_i,
  input  logic                                 rty_req_i,
  output logic [WB_DATA_WIDTH-1:0]             din_o,
  output logic                                 ack_o,
  output logic                                 err_o,
  output logic                                 rty_o
);

  localparam int unsigned SelWidth = WB_DATA_WIDTH / 8;
  localparam int unsigned IdxWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth = $clog2(MAX_WAIT + 1);
  localparam logic [WB_ADDR_WIDTH-1:0] DepthA = WB_ADDR_WIDTH'(DEPTH);
  localparam logic [2:0] CtiIncr = 3'b010;

  typedef enum logic [1:0] {StIdle, StWait, StResp, StBurst} state_e;

  state_e                     state_q, state_d;
  logic [CntWidth-1:0]        cnt_q, cnt_d;
  logic [WB_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                       burst_q, burst_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic                       rty_q, rty_d;
  logic [WB_DATA_WIDTH-1:0]   rdata_q;
  logic                       rd_load;
  logic [IdxWidth-1:0]        rd_idx;
  logic [WB_ADDR_WIDTH-1:0]   nxt_addr;
  logic                       mem_we;

  logic [WB_DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Next beat address: wrap modes keep the upper bits and roll the low 2/3/4 bits.
  function automatic logic [WB_ADDR_WIDTH-1:0] next_addr(input logic [WB_ADDR_WIDTH-1:0] a,
                                                         input logic [1:0]               bte);
    logic [WB_ADDR_WIDTH-1:0] inc;
    logic [WB_ADDR_WIDTH-1:0] mask;
    inc = a + WB_ADDR_WIDTH'(1);
    case (bte)
      2'b01:   mask = WB_ADDR_WIDTH'(3);
      2'b10:   mask = WB_ADDR_WIDTH'(7);
      2'b11:   mask = WB_ADDR_WIDTH'(15);
      default: mask = '1;
    endcase
    return (a & ~mask) | (inc & mask);
  endfunction

  assign nxt_addr = next_addr(addr_q, bte_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rty_d   = rty_q;
    rd_load = 1'b0;
    rd_idx  = addr_q[IdxWidth-1:0];
    unique case (state_q)
      StIdle: begin
        ack_d = 1'b0;
        err_d = 1'b0;
        rty_d = 1'b0;
        if (cyc_i && stb_i) begin
          addr_d  = adr_i;
          burst_d = (cti_i == CtiIncr);
          if (rty_req_i) begin
            state_d = StResp;
            rty_d   = 1'b1;
          end else if (adr_i >= DepthA) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else if (wait_cfg_i == '0) begin
            state_d = (cti_i == CtiIncr) ? StBurst : StResp;
            ack_d   = 1'b1;
            rd_load = 1'b1;
            rd_idx  = adr_i[IdxWidth-1:0];
          end else begin
            state_d = StWait;
            cnt_d   = wait_cfg_i;
          end
        end
      end
      StWait: begin
        if (!cyc_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntWidth'(1)) begin
          state_d = burst_q ? StBurst : StResp;
          cnt_d   = '0;
          ack_d   = 1'b1;
          rd_load = 1'b1;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StResp: begin
        // One terminating cycle; held while stb is low so the termination is seen.
        if (!cyc_i || stb_i) begin
          state_d = StIdle;
          ack_d   = 1'b0;
          err_d   = 1'b0;
          rty_d   = 1'b0;
        end
      end
      StBurst: begin
        if (!cyc_i || (stb_i && cti_i != CtiIncr)) begin
          state_d = StIdle;
          ack_d   = 1'b0;
        end else if (stb_i) begin
          addr_d = nxt_addr;
          if (nxt_addr >= DepthA) begin
            // Ran off the end of memory: the next beat is an err, then done.
            state_d = StResp;
            ack_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            rd_load = 1'b1;
            rd_idx  = nxt_addr[IdxWidth-1:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      burst_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      if (rd_load) begin
        rdata_q <= mem_q[rd_idx];
      end
    end
  end

  assign ack_o  = ack_q & cyc_i & stb_i;
  assign err_o  = err_q & cyc_i & stb_i;
  assign rty_o  = rty_q & cyc_i & stb_i;
  assign din_o  = ack_o ? rdata_q : '0;
  assign mem_we = ack_o & we_i;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < SelWidth; i++) begin
        if (sel_i[i]) begin
          mem_q[addr_q[IdxWidth-1:0]][8*i +: 8] <= dout_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_responder.sv
module tb_wb_burst_responder;

  localparam logic [2:0] KNone  = 3'd0;
  localparam logic [2:0] KAck   = 3'd1;
  localparam logic [2:0] KErr   = 3'd2;
  localparam logic [2:0] KRty   = 3'd3;
  localparam logic [2:0] KMulti = 3'd4;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  s;
    logic [3:0]  wc;
    logic        rq;
    logic [2:0]  kind;
    logic [5:0]  lat;
    logic        chk;
    logic [15:0] rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we, rty_req;
  logic [31:0] adr;
  logic [15:0] dout, din;
  logic [1:0]  sel, bte;
  logic [2:0]  cti;
  logic [3:0]  wait_cfg;
  logic        ack, err, rty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_burst_responder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cyc_i      (cyc),
    .stb_i      (stb),
    .we_i       (we),
    .adr_i      (adr),
    .dout_i     (dout),
    .sel_i      (sel),
    .cti_i      (cti),
    .bte_i      (bte),
    .wait_cfg_i (wait_cfg),
    .rty_req_i  (rty_req),
    .din_o      (din),
    .ack_o      (ack),
    .err_o      (err),
    .rty_o      (rty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic w, input logic [31:0] a, input logic [15:0] d,
                               input logic [1:0] s, input logic [3:0] wc, input logic rq,
                               input logic [2:0] kind, input logic [5:0] lat, input logic chk,
                               input logic [15:0] rd);
    return '{w: w, a: a, d: d, s: s, wc: wc, rq: rq, kind: kind, lat: lat, chk: chk, rd: rd};
  endfunction

  // Classic transfer, called just after a rising edge. lat counts cycles after the
  // acceptance edge (0 = cycle before acceptance).
  task automatic classic(input vec_t t, output logic [2:0] kind, output logic [5:0] lat,
                         output logic [15:0] rd);
    cyc = 1'b1; stb = 1'b1; we = t.w; adr = t.a; dout = t.d; sel = t.s;
    cti = 3'b000; bte = 2'b00; wait_cfg = t.wc; rty_req = t.rq;
    kind = KNone; lat = '0; rd = '0;
    for (int c = 0; c < 40 && kind == KNone; c++) begin
      @(negedge clk);
      if (ack || err || rty) begin
        if (32'(ack) + 32'(err) + 32'(rty) > 1) kind = KMulti;
        else if (ack)                            kind = KAck;
        else if (err)                            kind = KErr;
        else                                     kind = KRty;
        lat = 6'(c);
        rd  = din;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; rty_req = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t t);
    logic [2:0]  kind;
    logic [5:0]  lat;
    logic [15:0] rd;
    classic(t, kind, lat, rd);
    check({tag, " kind"}, 32'(kind), 32'(t.kind));
    check({tag, " latency"}, 32'(lat), 32'(t.lat));
    if (t.chk) check({tag, " din"}, 32'(rd), 32'(t.rd));
  endtask

  // One bus cycle: drive now (just after an edge), sample at the falling edge.
  task automatic beat(input string name, input logic c, input logic s, input logic [2:0] ct,
                      input logic [15:0] d, input logic ea, input logic ee, input logic cd,
                      input logic [15:0] ed);
    cyc = c; stb = s; cti = ct; dout = d;
    @(negedge clk);
    check({name, " ack"}, 32'(ack), 32'(ea));
    check({name, " err"}, 32'(err), 32'(ee));
    check({name, " rty"}, 32'(rty), 32'd0);
    if (cd) check({name, " din"}, 32'(din), 32'(ed));
    @(posedge clk); #1;
  endtask

  vec_t pre_v  [18];
  vec_t post_v [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pre_v[0]  = mkv(1, 5,   16'hA55A, 2'b11, 0,  0, KAck, 1,  0, 16'h0000);
    pre_v[1]  = mkv(0, 5,   16'h0000, 2'b11, 0,  0, KAck, 1,  1, 16'hA55A);
    pre_v[2]  = mkv(1, 5,   16'h1234, 2'b01, 0,  0, KAck, 1,  0, 16'h0000);
    pre_v[3]  = mkv(0, 5,   16'h0000, 2'b11, 3,  0, KAck, 4,  1, 16'hA534);
    pre_v[4]  = mkv(1, 0,   16'h0000, 2'b11, 0,  0, KAck, 1,  0, 16'h0000);
    pre_v[5]  = mkv(1, 8,   16'h0008, 2'b11, 0,  0, KAck, 1,  0, 16'h0000);
    pre_v[6]  = mkv(1, 9,   16'h0009, 2'b11, 0,  0, KAck, 1,  0, 16'h0000);
    pre_v[7]  = mkv(1, 10,  16'h000A, 2'b11, 0,  0, KAck, 1,  0, 16'h0000);
    pre_v[8]  = mkv(1, 11,  16'h000B, 2'b11, 0,  0, KAck, 1,  0, 16'h0000);
    pre_v[9]  = mkv(0, 256, 16'h0000, 2'b11, 0,  0, KErr, 1,  1, 16'h0000);
    pre_v[10] = mkv(0, 300, 16'h0000, 2'b11, 7,  0, KErr, 1,  1, 16'h0000);
    pre_v[11] = mkv(1, 5,   16'hFFFF, 2'b11, 3,  1, KRty, 1,  1, 16'h0000);
    pre_v[12] = mkv(0, 5,   16'h0000, 2'b11, 0,  0, KAck, 1,  1, 16'hA534);
    pre_v[13] = mkv(1, 255, 16'hBEEF, 2'b11, 1,  0, KAck, 2,  0, 16'h0000);
    pre_v[14] = mkv(1, 255, 16'h0011, 2'b10, 2,  0, KAck, 3,  0, 16'h0000);
    pre_v[15] = mkv(0, 255, 16'h0000, 2'b11, 15, 0, KAck, 16, 1, 16'h00EF);
    pre_v[16] = mkv(0, 8,   16'h0000, 2'b11, 1,  0, KAck, 2,  1, 16'h0008);
    pre_v[17] = mkv(0, 400, 16'h0000, 2'b11, 2,  1, KRty, 1,  1, 16'h0000);

    post_v[0] = mkv(0, 4,   16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h0003);
    post_v[1] = mkv(0, 5,   16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h0004);
    post_v[2] = mkv(0, 6,   16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h0001);
    post_v[3] = mkv(0, 7,   16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h0002);
    post_v[4] = mkv(0, 254, 16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h1111);
    post_v[5] = mkv(0, 255, 16'h0, 2'b11, 2, 0, KAck, 3, 1, 16'h2222);
    post_v[6] = mkv(0, 0,   16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h0000);
    post_v[7] = mkv(0, 9,   16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h0009);

    // Reset with a request already on the bus: nothing may respond.
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd5; dout = '0; sel = 2'b11;
    cti = 3'b000; bte = 2'b00; wait_cfg = '0; rty_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ack", 32'(ack), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset rty", 32'(rty), 32'd0);
    check("reset din", 32'(din), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) run_vec($sformatf("pre%0d", i), pre_v[i]);

    // Classic request held high: acks never in consecutive cycles.
    we = 1'b0; adr = 32'd5; sel = 2'b11; wait_cfg = '0; bte = 2'b00;
    beat("hold0", 1, 1, 3'b000, 16'h0, 0, 0, 0, 16'h0);
    beat("hold1", 1, 1, 3'b000, 16'h0, 1, 0, 1, 16'hA534);
    beat("hold2", 1, 1, 3'b000, 16'h0, 0, 0, 1, 16'h0000);
    beat("hold3", 1, 1, 3'b000, 16'h0, 1, 0, 1, 16'hA534);
    beat("hold4", 1, 1, 3'b000, 16'h0, 0, 0, 0, 16'h0);
    beat("hold5", 0, 0, 3'b000, 16'h0, 0, 0, 0, 16'h0);

    // Linear read burst from 8: four consecutive acks, 8..11.
    we = 1'b0; adr = 32'd8; bte = 2'b00;
    beat("rb0", 1, 1, 3'b010, 16'h0, 0, 0, 0, 16'h0);
    beat("rb1", 1, 1, 3'b010, 16'h0, 1, 0, 1, 16'h0008);
    beat("rb2", 1, 1, 3'b010, 16'h0, 1, 0, 1, 16'h0009);
    beat("rb3", 1, 1, 3'b010, 16'h0, 1, 0, 1, 16'h000A);
    beat("rb4", 1, 1, 3'b111, 16'h0, 1, 0, 1, 16'h000B);
    beat("rb5", 1, 1, 3'b111, 16'h0, 0, 0, 0, 16'h0);
    beat("rb6", 0, 0, 3'b000, 16'h0, 0, 0, 0, 16'h0);

    // 4-beat wrap write from 6 with a one-cycle stb gap.
    we = 1'b1; adr = 32'd6; bte = 2'b01; sel = 2'b11;
    beat("wb0", 1, 1, 3'b010, 16'h0001, 0, 0, 0, 16'h0);
    beat("wb1", 1, 1, 3'b010, 16'h0001, 1, 0, 0, 16'h0);
    beat("wb2", 1, 1, 3'b010, 16'h0002, 1, 0, 0, 16'h0);
    beat("wb3", 1, 0, 3'b010, 16'hDEAD, 0, 0, 0, 16'h0);
    beat("wb4", 1, 1, 3'b010, 16'h0003, 1, 0, 0, 16'h0);
    beat("wb5", 1, 1, 3'b111, 16'h0004, 1, 0, 0, 16'h0);
    beat("wb6", 1, 1, 3'b111, 16'hDEAD, 0, 0, 0, 16'h0);
    beat("wb7", 0, 0, 3'b000, 16'hDEAD, 0, 0, 0, 16'h0);

    // Linear write burst from DEPTH-2: two acks, then err without commit.
    we = 1'b1; adr = 32'd254; bte = 2'b00;
    beat("lb0", 1, 1, 3'b010, 16'h1111, 0, 0, 0, 16'h0);
    beat("lb1", 1, 1, 3'b010, 16'h1111, 1, 0, 0, 16'h0);
    beat("lb2", 1, 1, 3'b010, 16'h2222, 1, 0, 0, 16'h0);
    beat("lb3", 1, 1, 3'b010, 16'h3333, 0, 1, 1, 16'h0000);
    beat("lb4", 0, 0, 3'b000, 16'h3333, 0, 0, 0, 16'h0);

    // Abort during wait states: cyc drops before the ack would appear.
    we = 1'b1; adr = 32'd9; bte = 2'b00; wait_cfg = 4'd5;
    beat("ab0", 1, 1, 3'b000, 16'hFFFF, 0, 0, 0, 16'h0);
    beat("ab1", 1, 1, 3'b000, 16'hFFFF, 0, 0, 0, 16'h0);
    beat("ab2", 1, 1, 3'b000, 16'hFFFF, 0, 0, 0, 16'h0);
    for (int i = 3; i < 9; i++) beat($sformatf("ab%0d", i), 0, 0, 3'b000, 16'hFFFF, 0, 0, 0, 16'h0);
    wait_cfg = '0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("post%0d", i), post_v[i]);

    // Reset in the middle of a read burst.
    we = 1'b0; adr = 32'd8; bte = 2'b00;
    beat("rs0", 1, 1, 3'b010, 16'h0, 0, 0, 0, 16'h0);
    beat("rs1", 1, 1, 3'b010, 16'h0, 1, 0, 1, 16'h0008);
    beat("rs2", 1, 1, 3'b010, 16'h0, 1, 0, 1, 16'h0009);
    check("rs pre ack", 32'(ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs ack", 32'(ack), 32'd0);
    check("rs err", 32'(err), 32'd0);
    check("rs rty", 32'(rty), 32'd0);
    check("rs din", 32'(din), 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after reset", mkv(0, 10, 16'h0, 2'b11, 0, 0, KAck, 1, 1, 16'h000A));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
